// File: rtl/subpixel_pkg.sv
// Shared constants and read-side FSM encoding for the subpixel block collector.
package subpixel_pkg;
  localparam int PIXEL_W   = 8;
  localparam int NUM_PIXEL = 8;
  localparam int NUM_ROWS  = 8;
  localparam int ROW_W     = 3 * NUM_PIXEL * PIXEL_W;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;
endpackage

// File: rtl/subpixel_row_bank.sv
// One block of row storage: synchronous single write port, combinational read.
module subpixel_row_bank import subpixel_pkg::*; #(
  parameter int DEPTH = NUM_ROWS,
  parameter int W     = ROW_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  // Contents are intentionally unreset; full flags decide what is meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/subpixel_block_collector.sv
// Collects interpolator FIR rows into 8-row blocks in a ping-pong buffer and
// streams each finished block out one row per cycle.
module subpixel_block_collector #(
  parameter int NUM_PIXEL = 8,
  parameter int PIXEL_W   = 8,
  parameter int NUM_ROWS  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [NUM_PIXEL*PIXEL_W-1:0]         fir_out_a,
  input  logic [NUM_PIXEL*PIXEL_W-1:0]         fir_out_b,
  input  logic [NUM_PIXEL*PIXEL_W-1:0]         fir_out_c,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [3*NUM_PIXEL*PIXEL_W-1:0]       out_data,
  output logic [$clog2(NUM_ROWS)-1:0]          out_row,
  output logic                                 out_last,
  output logic                                 overflow,
  output logic [15:0]                          blocks_done,
  output subpixel_pkg::rd_state_e              dbg_rd_state
);
  import subpixel_pkg::*;

  localparam int LW = NUM_PIXEL * PIXEL_W;
  localparam int RW = 3 * LW;
  localparam int AW = $clog2(NUM_ROWS);
  localparam logic [AW-1:0] LAST_ROW = AW'(NUM_ROWS - 1);

  logic          wr_bank, rd_bank;
  logic [AW-1:0] wr_row, rd_row;
  logic [1:0]    full, full_nxt;
  logic          wr_accept, wr_done, rd_fire, rd_done;
  logic [RW-1:0] rdata0, rdata1;
  rd_state_e     state, state_nxt;

  // Handshake: a row transfers on any cycle where out_valid && out_ready.
  // out_valid never drops before the row-7 transfer; out_data is zero when idle.
  assign wr_accept = in_valid && !full[wr_bank];
  assign wr_done   = wr_accept && (wr_row == LAST_ROW);
  assign rd_fire   = out_valid && out_ready;
  assign rd_done   = rd_fire && (rd_row == LAST_ROW);

  subpixel_row_bank #(.DEPTH(NUM_ROWS), .W(RW)) u_bank0 (
    .clk   (clk),
    .we    (wr_accept && !wr_bank),
    .waddr (wr_row),
    .wdata ({fir_out_c, fir_out_b, fir_out_a}),
    .raddr (rd_row),
    .rdata (rdata0)
  );

  subpixel_row_bank #(.DEPTH(NUM_ROWS), .W(RW)) u_bank1 (
    .clk   (clk),
    .we    (wr_accept && wr_bank),
    .waddr (wr_row),
    .wdata ({fir_out_c, fir_out_b, fir_out_a}),
    .raddr (rd_row),
    .rdata (rdata1)
  );

  // Fill and release always hit different banks, so both can apply at once.
  always_comb begin
    full_nxt = full;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank  <= 1'b0;
      wr_row   <= '0;
      full     <= '0;
      overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (in_valid && full[wr_bank]) overflow <= 1'b1;
      if (wr_accept) begin
        if (wr_done) begin
          wr_row  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row <= wr_row + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bank     <= 1'b0;
      rd_row      <= '0;
      blocks_done <= '0;
    end else if (rd_fire) begin
      if (rd_done) begin
        rd_row      <= '0;
        rd_bank     <= ~rd_bank;
        blocks_done <= blocks_done + 16'd1;
      end else begin
        rd_row <= rd_row + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Looking at full_nxt lets out_valid rise right after the filling edge and
  // lets a bank filled on the release edge stream with no idle gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full_nxt[rd_bank]) state_nxt = STREAM;
      STREAM:  if (rd_done) state_nxt = full_nxt[~rd_bank] ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid    = (state == STREAM);
    out_row      = rd_row;
    out_last     = out_valid && (rd_row == LAST_ROW);
    out_data     = '0;
    if (out_valid) out_data = rd_bank ? rdata1 : rdata0;
    dbg_rd_state = state;
  end
endmodule

// File: tb/tb_subpixel_block_collector.sv
// Randomized and directed bench for subpixel_block_collector against a
// row-queue reference model of the ping-pong block buffer.
module tb_subpixel_block_collector;
  import subpixel_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [63:0]   fir_out_a, fir_out_b, fir_out_c;
  logic          out_valid, out_ready, out_last, overflow;
  logic [191:0]  out_data;
  logic [2:0]    out_row;
  logic [15:0]   blocks_done;
  rd_state_e     dbg_rd_state;

  int            n_vec  = 0;
  int            n_miss = 0;

  // Reference model: completed blocks waiting/streaming, rows of a partial block.
  logic [191:0]  exp_q[$];
  logic [191:0]  part_q[$];
  int            m_pend;
  int            m_rd_cnt;
  logic          m_ovf;
  logic [15:0]   m_blocks;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] REP  = 64'h0101_0101_0101_0101;

  always #5 clk = ~clk;

  subpixel_block_collector dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .fir_out_a    (fir_out_a),
    .fir_out_b    (fir_out_b),
    .fir_out_c    (fir_out_c),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_last     (out_last),
    .overflow     (overflow),
    .blocks_done  (blocks_done),
    .dbg_rd_state (dbg_rd_state)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
    m_pend   = 0;
    m_rd_cnt = 0;
    m_ovf    = 1'b0;
    m_blocks = 16'd0;
  endtask

  // One clock edge of the model. Acceptance is judged on the occupancy seen
  // before the edge: a row is kept unless both blocks are complete.
  task automatic model_edge(input logic iv, input logic [191:0] row, input logic rdy);
    int p0;
    p0 = m_pend;
    if (m_pend > 0 && rdy) begin
      void'(exp_q.pop_front());
      m_rd_cnt++;
      if (m_rd_cnt == 8) begin
        m_rd_cnt = 0;
        m_pend--;
        m_blocks = m_blocks + 16'd1;
      end
    end
    if (iv) begin
      if (p0 < 2) begin
        part_q.push_back(row);
        if (part_q.size() == 8) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          m_pend++;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic          ev;
    logic [191:0]  ed;
    ev = (m_pend > 0);
    ed = ev ? exp_q[0] : 192'd0;
    check("out_valid",   192'(out_valid),   192'(ev));
    check("out_row",     192'(out_row),     192'(ev ? m_rd_cnt : 0));
    check("out_last",    192'(out_last),    192'(ev && m_rd_cnt == 7));
    check("out_data",    out_data,          ed);
    check("overflow",    192'(overflow),    192'(m_ovf));
    check("blocks_done", 192'(blocks_done), 192'(m_blocks));
  endtask

  // Driver: apply inputs after a falling edge, model the rising edge, check.
  task automatic cycle(input logic iv, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic rdy);
    in_valid  = iv;
    fir_out_a = a;
    fir_out_b = b;
    fir_out_c = c;
    out_ready = rdy;
    @(posedge clk);
    model_edge(iv, {c, b, a}, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_row(input logic rdy);
    cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 64'd0, 64'd0, rdy);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check({tag, "_valid"}, 192'(out_valid),   192'd0);
    check({tag, "_data"},  out_data,          192'd0);
    check({tag, "_row"},   192'(out_row),     192'd0);
    check({tag, "_last"},  192'(out_last),    192'd0);
    check({tag, "_ovf"},   192'(overflow),    192'd0);
    check({tag, "_blk"},   192'(blocks_done), 192'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [63:0] a;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fir_out_a = '0;
    fir_out_b = '0;
    fir_out_c = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    do_reset("reset");

    // Patterned block, drained with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      a = 64'(i) * REP;
      cycle(1'b1, a, ~a, a ^ ONES, 1'b1);
    end
    check("t1_valid_rise", 192'(out_valid), 192'd1);
    idle(10, 1'b1);
    check("t1_blocks", 192'(blocks_done), 192'd1);

    // Consumer stall with both banks filling.
    for (int i = 0; i < 8; i++) rand_row(1'b0);
    idle(20, 1'b0);
    check("t2_stall_valid", 192'(out_valid), 192'd1);
    check("t2_stall_row",   192'(out_row),   192'd0);
    for (int i = 0; i < 8; i++) rand_row(1'b0);
    idle(20, 1'b1);

    // Overflow: 17th row arrives with both banks full.
    for (int i = 0; i < 17; i++) rand_row(1'b0);
    check("t3_overflow", 192'(overflow), 192'd1);
    idle(20, 1'b1);
    check("t3_blocks", 192'(blocks_done), 192'd5);

    // Reset after row 3 of a block has transferred.
    for (int i = 0; i < 8; i++) rand_row(1'b0);
    idle(4, 1'b1);
    check("t4_row_before_rst", 192'(out_row), 192'd4);
    do_reset("midrst");
    for (int i = 0; i < 8; i++) rand_row(1'b0);
    idle(10, 1'b1);
    check("t4_blocks_after", 192'(blocks_done), 192'd1);

    // Back-to-back blocks: fill of one bank coincides with release of the other.
    for (int i = 0; i < 40; i++) rand_row(1'b1);
    idle(10, 1'b1);
    check("t5_no_drop", 192'(overflow),    192'd0);
    check("t5_blocks",  192'(blocks_done), 192'd6);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0)
        rand_row($urandom_range(0, 2) != 0);
      else
        idle(1, $urandom_range(0, 1) != 0);
    end
    idle(20, 1'b1);

    // Counter wrap from a preloaded 65535.
    do_reset("wraprst");
    force dut.blocks_done = 16'hFFFF;
    #1 release dut.blocks_done;
    m_blocks = 16'hFFFF;
    check("wrap_preload", 192'(blocks_done), 192'hFFFF);
    for (int i = 0; i < 8; i++) rand_row(1'b1);
    idle(10, 1'b1);
    check("wrap_zero", 192'(blocks_done), 192'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/subpixel_block_collector.md
# subpixel_block_collector

Downstream stage of the subpixel interpolator. Captures the three 64-bit FIR result rows (a, b, c: 8 pixels × 8 bits each) whenever the interpolator flags an output row. Assembles them into complete 8-row blocks in a ping-pong buffer. Streams each finished block out one row per cycle over a valid/ready handshake, so a stalled consumer never corrupts a block that is still being captured.

## Interface
Parameters:
- NUM_PIXEL, 8, pixels per row
- PIXEL_W, 8, bits per pixel
- NUM_ROWS, 8, rows per block

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  capture strobe (interpolator load_out)
- fir_out_a  in  64  row of a-position subpixels, pixel i at [8i+:8]
- fir_out_b  in  64  row of b-position subpixels
- fir_out_c  in  64  row of c-position subpixels
- out_valid  out  1  a full block is available at the read bank
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  192  {c, b, a} for the current read row
- out_row  out  3  row index of out_data, 0..7
- out_last  out  1  out_valid && out_row == 7
- overflow  out  1  sticky: a captured row was dropped
- blocks_done  out  16  count of fully streamed blocks; wraps at 65535→0

## Operation
- Storage: two banks × 8 rows × 192 bits. Per-bank full flag.
- Write side: wr_bank (1b), wr_row (3b).
  - On in_valid with full[wr_bank]==0: write row wr_row of wr_bank and increment wr_row.
  - When wr_row==7 on that write: set full[wr_bank], toggle wr_bank, set wr_row=0.
- Drop: in_valid with full[wr_bank]==1 discards the data. Set overflow. wr_row, wr_bank and both banks are unchanged.
- Read side: two-state FSM per read bank.
  - IDLE: out_valid=0. Move to STREAM when full[rd_bank]==1.
  - STREAM: out_valid=1, out_row=rd_row.
  - A transfer occurs when out_valid && out_ready; rd_row then increments.
  - On the transfer at rd_row==7: clear full[rd_bank], toggle rd_bank, set rd_row=0, increment blocks_done. Next state is STREAM if the other bank is already full, else IDLE.
- out_data is combinational from the read bank/row. It is forced to 0 when out_valid==0.
- Simultaneous events:
  - A final write filling one bank and a final read releasing the other bank in the same cycle both take effect.
  - A write never targets the bank being read; full-flag gating guarantees this.
- out_ready held high with out_valid low has no effect. out_valid, once high, stays high until the row-7 transfer, regardless of out_ready.

## Timing
- Reset (rst low, asynchronous) clears the following:
  - outputs: out_valid=0, out_data=0, out_row=0, out_last=0, overflow=0, blocks_done=0
  - internal state: wr_bank=0, wr_row=0, rd_bank=0, rd_row=0, both full flags=0
- Bank contents are not reset.
- Reset mid-block discards any partial or pending block. No output is produced for it.
- Capture latency: the 8th accepted row written at edge k makes out_valid high in the cycle following edge k.
- With out_ready held high, one row transfers per cycle, so a block drains in 8 cycles.
- Back-to-back blocks at one row per cycle input and out_ready=1 run with zero drops.

## Structure
- Shared package subpixel_pkg holds:
  - constants: PIXEL_W, NUM_PIXEL, NUM_ROWS, ROW_W = 3·NUM_PIXEL·PIXEL_W = 192
  - read FSM state encoding: IDLE=0, STREAM=1
- Sub-module subpixel_row_bank: 8×192 storage with a single synchronous write port (we, waddr, wdata) and a combinational read port (raddr). Instantiated twice.
- Top level holds the counters, full flags, FSM, and the output mux/gating.

## Test plan
- Reset then 8 in_valid cycles with a=row index·0x0101010101010101, b=~a, c=a^0xFF… → out_valid rises the cycle after the 8th write. Rows 0..7 stream in order with out_ready=1; out_last at row 7; blocks_done=1.
- Consumer stall: fill bank 0, hold out_ready=0 for 20 cycles → out_valid stays 1 and out_row stays 0. Bank 1 fills from 8 more rows unchanged. Release out_ready → 16 rows stream contiguously.
- Overflow: out_ready=0, apply 17 rows → overflow=1 after the 17th row. After draining, rows 0..15 are output exactly, and the 17th row is absent.
- Simultaneous fill/release: time the 8th write of bank 1 to coincide with the row-7 transfer of bank 0 → no gap. out_valid stays 1 and the next row is bank 1 row 0.
- Async reset mid-stream: assert rst low after row 3 transfers → all outputs 0 immediately, without waiting for a clock edge. Post-reset, a fresh block streams correctly, and blocks_done restarts at 0 then 1.
- Wrap: preload via 65536 streamed blocks (or force) → blocks_done wraps 65535→0.
